riscv_lsu: RTL

Load/store unit sitting directly downstream of the single-cycle ALU. It consumes the ALU result as the effective address and rs2 as store data, then runs one data-memory transaction over a req/ack handshake. It generates byte enables and replicated store data, and aligns and sign- or zero-extends load data. It reports misalignment, illegal-size and bus-timeout errors, and asserts busy so the core stalls while an access is outstanding.

---
 rtl/riscv_lsu_pkg.sv | 42 ++++
 rtl/lsu_load_align.sv | 29 ++
 rtl/riscv_lsu.sv | 181 ++++++++++++++++++
 3 files changed

// File: rtl/riscv_lsu_pkg.sv
// Shared constants for the load/store unit: funct3 encodings, FSM states,
// response error codes and the request legality helpers.
package riscv_lsu_pkg;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  typedef logic [1:0] lsu_state_t;
  localparam lsu_state_t IDLE   = 2'd0;
  localparam lsu_state_t ACCESS = 2'd1;
  localparam lsu_state_t RESP   = 2'd2;

  localparam logic [1:0] ERR_OK       = 2'b00;
  localparam logic [1:0] ERR_MISALIGN = 2'b01;
  localparam logic [1:0] ERR_ILLEGAL  = 2'b10;
  localparam logic [1:0] ERR_TIMEOUT  = 2'b11;

  // Unsigned widths exist only for loads; 011/110/111 never encode a memory op.
  function automatic logic f3_illegal(input logic we, input logic [2:0] f3);
    logic ill;
    case (f3)
      F3_B, F3_H, F3_W: ill = 1'b0;
      F3_BU, F3_HU:     ill = we;
      default:          ill = 1'b1;
    endcase
    return ill;
  endfunction

  function automatic logic f3_misaligned(input logic [2:0] f3, input logic [1:0] off);
    logic mis;
    case (f3)
      F3_H, F3_HU: mis = off[0];
      F3_W:        mis = (off != 2'b00);
      default:     mis = 1'b0;
    endcase
    return mis;
  endfunction

endpackage

// File: rtl/lsu_load_align.sv
// Load data alignment: shift the addressed lane down, then sign- or
// zero-extend according to the access width.
module lsu_load_align
  import riscv_lsu_pkg::*;
(
  input  logic [31:0] rdata,
  input  logic [1:0]  offset,
  input  logic [2:0]  funct3,
  output logic [31:0] data
);

  logic [31:0] w;

  assign w = rdata >> {offset, 3'b000};

  // Select width and extension mode.
  always_comb begin
    data = w;
    case (funct3)
      F3_B:    data = {{24{w[7]}}, w[7:0]};
      F3_BU:   data = {24'h0, w[7:0]};
      F3_H:    data = {{16{w[15]}}, w[15:0]};
      F3_HU:   data = {16'h0, w[15:0]};
      F3_W:    data = w;
      default: data = w;
    endcase
  end

endmodule

// File: rtl/riscv_lsu.sv
// Load/store unit: accepts one memory op from EX, runs a single req/ack bus
// transaction (or reports an error without touching the bus) and returns a
// one-cycle response. busy stalls the core while an op is outstanding.
module riscv_lsu
  import riscv_lsu_pkg::*;
#(
  parameter int unsigned TIMEOUT = 16,
  parameter int unsigned ADDR_W  = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_we,
  input  logic [2:0]        req_funct3,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [31:0]       req_wdata,
  input  logic [4:0]        req_rd,
  output logic              mem_req,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [3:0]        mem_be,
  output logic [31:0]       mem_wdata,
  input  logic              mem_ack,
  input  logic [31:0]       mem_rdata,
  output logic              rsp_valid,
  output logic [4:0]        rsp_rd,
  output logic [31:0]       rsp_data,
  output logic [1:0]        rsp_err,
  output logic              busy
);

  localparam logic [7:0] CntLast = 8'(TIMEOUT - 1);

  lsu_state_t        state_q, state_d;
  logic [7:0]        cnt_q, cnt_d;
  logic [31:0]       rsp_data_q, rsp_data_d;
  logic [4:0]        rsp_rd_q, rsp_rd_d;
  logic [1:0]        rsp_err_q, rsp_err_d;

  logic              we_q;
  logic [2:0]        f3_q;
  logic [ADDR_W-1:0] addr_q;
  logic [4:0]        rd_q;
  logic [3:0]        be_q;
  logic [31:0]       wdata_q;

  logic              accept;
  logic              req_illegal;
  logic              req_misalign;
  logic [3:0]        be_new;
  logic [31:0]       wdata_new;
  logic [31:0]       load_data;

  assign accept       = (state_q == IDLE) && req_valid;
  assign req_illegal  = f3_illegal(req_we, req_funct3);
  assign req_misalign = f3_misaligned(req_funct3, req_addr[1:0]);

  // Store lane enables and replicated write data; loads always read the full word.
  always_comb begin
    be_new    = 4'b1111;
    wdata_new = req_wdata;
    case (req_funct3[1:0])
      2'b00: begin
        be_new    = 4'b0001 << req_addr[1:0];
        wdata_new = {4{req_wdata[7:0]}};
      end
      2'b01: begin
        be_new    = 4'b0011 << req_addr[1:0];
        wdata_new = {2{req_wdata[15:0]}};
      end
      default: begin
        be_new    = 4'b1111;
        wdata_new = req_wdata;
      end
    endcase
    if (!req_we) be_new = 4'b1111;
  end

  lsu_load_align u_load_align (
    .rdata  (mem_rdata),
    .offset (addr_q[1:0]),
    .funct3 (f3_q),
    .data   (load_data)
  );

  // Next-state, timeout counter and response capture.
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    rsp_data_d = rsp_data_q;
    rsp_rd_d   = rsp_rd_q;
    rsp_err_d  = rsp_err_q;
    case (state_q)
      IDLE: begin
        cnt_d = '0;
        if (req_valid) begin
          rsp_data_d = '0;
          rsp_rd_d   = '0;
          if (req_illegal) begin
            state_d   = RESP;
            rsp_err_d = ERR_ILLEGAL;
          end else if (req_misalign) begin
            state_d   = RESP;
            rsp_err_d = ERR_MISALIGN;
          end else begin
            state_d   = ACCESS;
            rsp_err_d = ERR_OK;
          end
        end
      end
      ACCESS: begin
        // An ack on the final counted cycle still completes normally.
        if (mem_ack) begin
          state_d    = RESP;
          rsp_err_d  = ERR_OK;
          rsp_data_d = we_q ? 32'h0 : load_data;
          rsp_rd_d   = we_q ? 5'd0 : rd_q;
        end else if (cnt_q == CntLast) begin
          state_d    = RESP;
          rsp_err_d  = ERR_TIMEOUT;
          rsp_data_d = '0;
          rsp_rd_d   = '0;
        end else begin
          cnt_d = cnt_q + 8'd1;
        end
      end
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Control state; reset abandons any in-flight access.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      rsp_data_q <= '0;
      rsp_rd_q   <= '0;
      rsp_err_q  <= ERR_OK;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      rsp_data_q <= rsp_data_d;
      rsp_rd_q   <= rsp_rd_d;
      rsp_err_q  <= rsp_err_d;
    end
  end

  // Request latch; these registers drive the bus directly so it stays stable in ACCESS.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      we_q    <= 1'b0;
      f3_q    <= '0;
      addr_q  <= '0;
      rd_q    <= '0;
      be_q    <= '0;
      wdata_q <= '0;
    end else if (accept) begin
      we_q    <= req_we;
      f3_q    <= req_funct3;
      addr_q  <= req_addr;
      rd_q    <= req_rd;
      be_q    <= be_new;
      wdata_q <= wdata_new;
    end
  end

  assign req_ready = (state_q == IDLE);
  assign busy      = ~req_ready;
  assign mem_req   = (state_q == ACCESS);
  assign mem_we    = we_q;
  assign mem_addr  = {addr_q[ADDR_W-1:2], 2'b00};
  assign mem_be    = be_q;
  assign mem_wdata = wdata_q;
  assign rsp_valid = (state_q == RESP);
  assign rsp_data  = rsp_valid ? rsp_data_q : 32'h0;
  assign rsp_rd    = rsp_valid ? rsp_rd_q : 5'd0;
  assign rsp_err   = rsp_valid ? rsp_err_q : ERR_OK;

endmodule
